count_sequencer: RTL and testbench

COUNT_SEQUENCER -- requirements
Module: count_sequencer

---
 rtl/counter_ctrl_pkg.sv | 15 +
 rtl/up_counter.sv | 26 ++
 rtl/count_sequencer.sv | 140 ++++++++++++++
 tb/tb_count_sequencer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the count sequencer.
// Holds the 2-bit state encoding seen on the state output and the default
// counter / limit width.
package counter_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

endpackage

// File: rtl/up_counter.sv
// Datapath counter for the count sequencer.
// Ports:
//   clk   - clock, rising edge active
//   rst   - asynchronous active-high reset, clears count
//   clr   - synchronous clear (has priority over en)
//   en    - increment by one, WIDTH-bit wrap-around arithmetic
//   count - registered counter value
module up_counter
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + WIDTH'(1);
  end

endmodule

// File: rtl/count_sequencer.sv
// Start/stop controlled counter sequencer with one-shot and auto-reload modes.
// Ports:
//   clk       - clock, rising edge active
//   rst       - asynchronous active-high reset
//   start     - run request (accept in IDLE/DONE, resume in PAUSE)
//   stop      - pause (RUN) / abort (PAUSE, DONE); beats start on the same edge
//   mode      - 0 one-shot, 1 auto-reload; captured on accept
//   limit     - terminal count; captured on accept
//   start_ack - one-cycle pulse after an accepted start (not on resume)
//   busy      - high in RUN and PAUSE
//   done      - one-cycle pulse after the terminal count was reached
//   count     - current counter value
//   state     - IDLE=00 RUN=01 PAUSE=10 DONE=11
// All outputs come straight from flops.
module count_sequencer
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  output logic             start_ack,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state
);

  state_t           r_state;
  logic [WIDTH-1:0] r_limit;
  logic             r_mode;
  logic             r_ack;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_count;
  logic             w_clr;
  logic             w_en;
  logic             w_at_term;

  assign w_at_term = (w_count == r_limit);

  // Counter control. Clearing is only needed when leaving for a fresh run,
  // on auto-reload wrap, or on abort to IDLE; everything else holds.
  always_comb begin
    w_clr = 1'b0;
    w_en  = 1'b0;
    case (r_state)
      IDLE:  w_clr = start && !stop;
      RUN: begin
        if (!stop) begin
          if (w_at_term) w_clr = r_mode;
          else           w_en  = 1'b1;
        end
      end
      PAUSE: w_clr = stop;
      DONE:  w_clr = stop || start;
      default: w_clr = 1'b1;
    endcase
  end

  up_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_clr),
    .en    (w_en),
    .count (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_limit <= '0;
      r_mode  <= 1'b0;
      r_ack   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_ack  <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start && !stop) begin
            r_state <= RUN;
            r_limit <= limit;
            r_mode  <= mode;
            r_ack   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            r_state <= PAUSE;
          end else if (w_at_term) begin
            r_done <= 1'b1;
            if (!r_mode) begin
              r_state <= DONE;
              r_busy  <= 1'b0;
            end
          end
        end
        PAUSE: begin
          if (stop) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (start) begin
            // resume: limit/mode stay as captured, no acknowledge
            r_state <= RUN;
          end
        end
        DONE: begin
          if (stop) begin
            r_state <= IDLE;
          end else if (start) begin
            r_state <= RUN;
            r_limit <= limit;
            r_mode  <= mode;
            r_ack   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign start_ack = r_ack;
  assign busy      = r_busy;
  assign done      = r_done;
  assign count     = w_count;
  assign state     = r_state;

endmodule

// File: tb/tb_count_sequencer.sv
module tb_count_sequencer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] limit = '0;
  logic         start_ack, busy, done;
  logic [W-1:0] count;
  logic [1:0]   state;

  int total = 0;
  int bad   = 0;

  count_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
    .limit(limit), .start_ack(start_ack), .busy(busy), .done(done),
    .count(count), .state(state)
  );

  always #5 clk = ~clk;

  // Reference model: phase numbers use the published state codes,
  // 0 idle, 1 running, 2 paused, 3 finished.
  int m_phase, m_cnt, m_lim;
  bit m_auto, m_ack, m_done;

  function automatic void model_reset();
    m_phase = 0; m_cnt = 0; m_lim = 0; m_auto = 0; m_ack = 0; m_done = 0;
  endfunction

  function automatic void model_step(bit s, bit p, bit m, int l);
    m_ack = 0; m_done = 0;
    if (p) begin
      if (m_phase == 1) m_phase = 2;
      else if (m_phase != 0) begin m_phase = 0; m_cnt = 0; end
    end else if (s && (m_phase == 0 || m_phase == 3)) begin
      m_phase = 1; m_cnt = 0; m_lim = l; m_auto = m; m_ack = 1;
    end else if (s && m_phase == 2) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      if (m_cnt == m_lim) begin
        m_done = 1;
        if (m_auto) m_cnt = 0;
        else        m_phase = 3;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
  endfunction

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_model(string nm);
    chk({nm, ".state"}, int'(state), m_phase);
    chk({nm, ".count"}, int'(count), m_cnt);
    chk({nm, ".ack"},   int'(start_ack), int'(m_ack));
    chk({nm, ".done"},  int'(done), int'(m_done));
    chk({nm, ".busy"},  int'(busy), int'(m_phase == 1 || m_phase == 2));
  endtask

  // Drive inputs, take one rising edge, sample 1 time unit later.
  task automatic tick(bit s, bit p, bit m, int l);
    start = s; stop = p; mode = m; limit = W'(l);
    @(posedge clk);
    #1;
    model_step(s, p, m, l);
  endtask

  typedef struct {
    bit s, p, m; int l;
    int st, cnt; bit ack, dn, bsy;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(bit s, bit p, bit m, int l,
                             int st, int cnt, bit ack, bit dn, bit bsy);
    vec_t r;
    r.s = s; r.p = p; r.m = m; r.l = l;
    r.st = st; r.cnt = cnt; r.ack = ack; r.dn = dn; r.bsy = bsy;
    return r;
  endfunction

  task automatic async_reset_check(string nm);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk({nm, ".state"}, int'(state), 0);
    chk({nm, ".count"}, int'(count), 0);
    chk({nm, ".done"},  int'(done), 0);
    chk({nm, ".busy"},  int'(busy), 0);
    chk({nm, ".ack"},   int'(start_ack), 0);
    #1 rst = 1'b0;
  endtask

  initial begin
    model_reset();
    // one-shot limit 5, limit/mode wiggled mid-run, start in RUN ignored
    tbl.push_back(v(1,0,0,5, 1,0,1,0,1));
    tbl.push_back(v(0,0,0,2, 1,1,0,0,1));
    tbl.push_back(v(0,0,1,2, 1,2,0,0,1));
    tbl.push_back(v(0,0,0,5, 1,3,0,0,1));
    tbl.push_back(v(1,0,0,5, 1,4,0,0,1));
    tbl.push_back(v(0,0,0,5, 1,5,0,0,1));
    tbl.push_back(v(0,0,0,5, 3,5,0,1,0));
    tbl.push_back(v(0,0,0,5, 3,5,0,0,0));
    tbl.push_back(v(0,1,0,5, 0,0,0,0,0));
    // start+stop together in IDLE: stop wins
    tbl.push_back(v(1,1,0,9, 0,0,0,0,0));
    // limit 9, pause at 4 for three cycles, resume without recapture
    tbl.push_back(v(1,0,0,9, 1,0,1,0,1));
    for (int i = 1; i <= 4; i++) tbl.push_back(v(0,0,0,9, 1,i,0,0,1));
    tbl.push_back(v(0,1,0,9, 2,4,0,0,1));
    tbl.push_back(v(0,0,0,9, 2,4,0,0,1));
    tbl.push_back(v(0,0,0,3, 2,4,0,0,1));
    tbl.push_back(v(1,0,1,3, 1,4,0,0,1));
    for (int i = 5; i <= 9; i++) tbl.push_back(v(0,0,0,3, 1,i,0,0,1));
    tbl.push_back(v(0,0,0,3, 3,9,0,1,0));
    // restart from DONE, pause, then start+stop in PAUSE aborts to IDLE
    tbl.push_back(v(1,0,0,7, 1,0,1,0,1));
    tbl.push_back(v(0,0,0,7, 1,1,0,0,1));
    tbl.push_back(v(0,1,0,7, 2,1,0,0,1));
    tbl.push_back(v(1,1,0,7, 0,0,0,0,0));

    // reset state
    #3;
    chk("reset.state", int'(state), 0);
    chk("reset.count", int'(count), 0);
    chk("reset.busy",  int'(busy), 0);
    chk("reset.done",  int'(done), 0);
    chk("reset.ack",   int'(start_ack), 0);
    @(negedge clk) rst = 1'b0;

    foreach (tbl[i]) begin
      tick(tbl[i].s, tbl[i].p, tbl[i].m, tbl[i].l);
      chk($sformatf("tbl%0d.state", i), int'(state), tbl[i].st);
      chk($sformatf("tbl%0d.count", i), int'(count), tbl[i].cnt);
      chk($sformatf("tbl%0d.ack", i),   int'(start_ack), int'(tbl[i].ack));
      chk($sformatf("tbl%0d.done", i),  int'(done), int'(tbl[i].dn));
      chk($sformatf("tbl%0d.busy", i),  int'(busy), int'(tbl[i].bsy));
    end

    // auto-reload limit 3: 0,1,2,3,0,... done every 4 cycles, busy held
    tick(1,0,1,3); chk_model("auto3.go");
    for (int k = 0; k < 12; k++) begin
      tick(0,0,0,0); chk_model("auto3");
    end
    tick(0,1,0,0); tick(0,1,0,0); chk_model("auto3.abort");

    // full range one-shot: 0..15, one done, no wrap
    tick(1,0,0,15); chk_model("full.go");
    for (int k = 0; k < 18; k++) begin
      tick(0,0,0,0); chk_model("full");
    end
    tick(0,1,0,0); chk_model("full.idle");

    // limit 0 auto-reload: done every cycle, count stays 0
    tick(1,0,1,0); chk_model("zauto.go");
    for (int k = 0; k < 4; k++) begin
      tick(0,0,0,0); chk_model("zauto");
    end
    tick(0,1,0,0); tick(0,1,0,0);
    // limit 0 one-shot: straight to DONE after one RUN cycle
    tick(1,0,0,0); chk_model("zone.go");
    tick(0,0,0,0); chk_model("zone.fin");
    tick(0,0,0,0); chk_model("zone.hold");

    // asynchronous reset at count 6 of a limit-10 run, then normal restart
    tick(1,0,0,10);
    for (int k = 0; k < 6; k++) tick(0,0,0,0);
    chk_model("rst10.pre");
    async_reset_check("rst10.async");
    tick(0,0,0,0); chk_model("rst10.after");
    tick(1,0,0,2); chk_model("rst10.restart");

    // randomized run against the model, with occasional async reset
    for (int k = 0; k < 400; k++) begin
      tick($urandom_range(0,3) == 0, $urandom_range(0,9) == 0,
           1'($urandom_range(0,1)), int'($urandom_range(0,15)));
      chk_model($sformatf("rnd%0d", k));
      if ($urandom_range(0,59) == 0) async_reset_check($sformatf("rnd%0d.rst", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
